// File: rtl/lp_pipe_mult_mgr.sv
// Self-managed multiply pipeline: bubble-collapsing stall, per-stage load enables, ID tracking.
// Optional LP_PIPE_MULT_MGR_STALL_CNT_EN adds a saturating stall_cnt output.
module lp_pipe_mult_mgr #(
  parameter  int A_WIDTH  = 8,
  parameter  int B_WIDTH  = 8,
  parameter  int ID_WIDTH = 3,
  parameter  int STAGES   = 4,
  parameter  int TC_MODE  = 0,
  localparam int PW       = A_WIDTH + B_WIDTH,
  localparam int CW       = $clog2(STAGES + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                init_n,
  input  logic                launch,
  input  logic [ID_WIDTH-1:0] launch_id,
  input  logic [A_WIDTH-1:0]  a,
  input  logic [B_WIDTH-1:0]  b,
  output logic                pipe_full,
  output logic                pipe_ovf,
  output logic                arrive,
  output logic [ID_WIDTH-1:0] arrive_id,
  output logic [PW-1:0]       product,
  input  logic                accept_n,
  output logic                push_out_n,
  output logic [CW-1:0]       pipe_census,
  output logic [STAGES-1:0]   pipe_en_bus
`ifdef LP_PIPE_MULT_MGR_STALL_CNT_EN
  ,
  output logic [15:0]         stall_cnt
`endif
);

  localparam int LS = STAGES - 1;

  logic                clr;
  logic                pop;
  logic                full;
  logic [STAGES-1:0]   v;
  logic [STAGES-1:0]   adv;
  logic [STAGES-1:0]   en;
  logic [PW-1:0]       prod_in;
  logic [CW-1:0]       census_q;
  logic                ovf_q;
  logic [ID_WIDTH-1:0] id_q  [STAGES];
  logic [PW-1:0]       dat_q [STAGES];

  assign clr = ~rst_n | ~init_n;

  generate
    if (TC_MODE != 0) begin : g_tc
      assign prod_in = {{B_WIDTH{a[A_WIDTH-1]}}, a}
                     * {{A_WIDTH{b[B_WIDTH-1]}}, b};
    end else begin : g_uns
      assign prod_in = {{B_WIDTH{1'b0}}, a}
                     * {{A_WIDTH{1'b0}}, b};
    end
  endgenerate

  // A stage advances if any stage downstream holds a bubble, or the
  // consumer pops the last stage; the running hole flag avoids a
  // bit-level feedback through adv itself.
  always_comb begin
    logic hole;
    hole = 1'b0;
    adv  = '0;
    for (int i = LS; i >= 0; i--) begin
      adv[i] = v[i] & (hole | ~accept_n);
      hole   = hole | ~v[i];
    end
  end

  assign full = v[0] & ~adv[0];
  assign pop  = v[LS] & ~accept_n;

  always_comb begin
    en    = '0;
    en[0] = launch & ~full;
    for (int i = 1; i < STAGES; i++) begin
      en[i] = v[i-1] & (~v[i] | adv[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      v        <= '0;
      census_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        v[i] <= en[i] | (v[i] & ~adv[i]);
      end
      ovf_q <= ovf_q | (launch & full);
      if (en[0] & ~pop) begin
        census_q <= census_q + CW'(1);
      end else if (~en[0] & pop) begin
        census_q <= census_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      id_q[0]  <= '0;
      dat_q[0] <= '0;
    end else if (en[0]) begin
      id_q[0]  <= launch_id;
      dat_q[0] <= prod_in;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 1; i < STAGES; i++) begin
      if (clr) begin
        id_q[i]  <= '0;
        dat_q[i] <= '0;
      end else if (en[i]) begin
        id_q[i]  <= id_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign pipe_full   = full;
  assign pipe_ovf    = ovf_q;
  assign arrive      = v[LS];
  assign arrive_id   = id_q[LS];
  assign product     = dat_q[LS];
  assign push_out_n  = ~pop;
  assign pipe_census = census_q;
  assign pipe_en_bus = en;

`ifdef LP_PIPE_MULT_MGR_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (clr) begin
      stall_cnt <= '0;
    end else if (v[LS] & accept_n & (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lp_pipe_mult_mgr.sv
// Bench for lp_pipe_mult_mgr: queue-of-operations reference model, randomized traffic.
// Two instances (unsigned and two's-complement) share one stimulus stream.
module tb_lp_pipe_mult_mgr;

  localparam int S = 4;

  typedef struct {
    logic [2:0]  id;
    logic [15:0] pu;
    logic [15:0] ps;
    int          pos;
  } op_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init_n = 1'b1;
  logic        launch = 1'b0;
  logic        accept_n = 1'b1;
  logic [2:0]  launch_id = '0;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;

  logic        pipe_full, pipe_ovf, arrive, push_out_n;
  logic [2:0]  arrive_id, census;
  logic [15:0] product;
  logic [3:0]  en_bus;
  logic        tc_full, tc_ovf, tc_arrive, tc_push_n;
  logic [2:0]  tc_id, tc_census;
  logic [15:0] tc_product;
  logic [3:0]  tc_en;
`ifdef LP_PIPE_MULT_MGR_STALL_CNT_EN
  logic [15:0] stall_cnt, tc_stall_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  op_t  q[$];
  op_t  nq[$];
  bit   m_ovf, m_ovf_nx;
  bit   e_arrive, e_push_n, e_full, e_ovf;
  bit   [3:0]  e_en;
  bit   [2:0]  e_id;
  bit   [15:0] e_pu, e_ps;
  int   e_census;

  always #5 clk = ~clk;

  lp_pipe_mult_mgr #(.TC_MODE(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .init_n(init_n),
    .launch(launch), .launch_id(launch_id), .a(a), .b(b),
    .pipe_full(pipe_full), .pipe_ovf(pipe_ovf),
    .arrive(arrive), .arrive_id(arrive_id), .product(product),
    .accept_n(accept_n), .push_out_n(push_out_n),
    .pipe_census(census), .pipe_en_bus(en_bus)
`ifdef LP_PIPE_MULT_MGR_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  lp_pipe_mult_mgr #(.TC_MODE(1)) u_tc (
    .clk(clk), .rst_n(rst_n), .init_n(init_n),
    .launch(launch), .launch_id(launch_id), .a(a), .b(b),
    .pipe_full(tc_full), .pipe_ovf(tc_ovf),
    .arrive(tc_arrive), .arrive_id(tc_id), .product(tc_product),
    .accept_n(accept_n), .push_out_n(tc_push_n),
    .pipe_census(tc_census), .pipe_en_bus(tc_en)
`ifdef LP_PIPE_MULT_MGR_STALL_CNT_EN
    , .stall_cnt(tc_stall_cnt)
`endif
  );

  // Drive one cycle's inputs, then predict outputs and next state at negedge.
  task automatic drive(input bit l, input bit [2:0] id, input bit [7:0] av,
                       input bit [7:0] bv, input bit acn, input bit ini);
    int lim, np, sa, sb;
    bit pop;
    op_t o;
    launch = l; launch_id = id; a = av; b = bv;
    accept_n = acn; init_n = ini;
    @(negedge clk);
    e_arrive = (q.size() > 0) && (q[0].pos == S-1);
    pop      = e_arrive && !acn;
    e_push_n = !pop;
    e_full   = (q.size() == S) && !pop;
    e_census = q.size();
    e_ovf    = m_ovf;
    e_en     = '0;
    nq       = {};
    lim      = S;
    foreach (q[k]) begin
      if (k == 0 && pop) continue;
      o  = q[k];
      np = (o.pos + 1 < lim) ? o.pos + 1 : o.pos;
      if (np != o.pos) e_en[np] = 1'b1;
      o.pos = np;
      nq.push_back(o);
      lim = np;
    end
    if (l && !e_full) begin
      sa = av[7] ? int'(av) - 256 : int'(av);
      sb = bv[7] ? int'(bv) - 256 : int'(bv);
      o.id  = id;
      o.pu  = 16'(av) * 16'(bv);
      o.ps  = 16'(sa * sb);
      o.pos = 0;
      nq.push_back(o);
      e_en[0] = 1'b1;
    end
    m_ovf_nx = m_ovf | (l & e_full);
    if (e_arrive) begin
      e_id = q[0].id; e_pu = q[0].pu; e_ps = q[0].ps;
    end
  endtask

  task automatic commit();
    @(posedge clk);
    if (!rst_n || !init_n) begin
      q = {}; m_ovf = 1'b0;
    end else begin
      q = nq; m_ovf = m_ovf_nx;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1, 3'd5, 8'd7, 8'd9, 1, 1); commit();
    drive(1, 3'd6, 8'd3, 8'd4, 0, 1); commit();
    rst_n = 1'b1;
    drive(0, 3'd0, 8'd0, 8'd0, 1, 1);
    n_tests++;
    if ({arrive, push_out_n, pipe_full, pipe_ovf} !== 4'b0100) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 0100",
               {arrive, push_out_n, pipe_full, pipe_ovf});
    end
    n_tests++;
    if ({arrive_id, product, tc_product} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_data: got id %0d prod %h/%h want 0",
               arrive_id, product, tc_product);
    end
    n_tests++;
    if ({census, en_bus} !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_census_en: got %0d %b want 0 0000",
               census, en_bus);
    end
    commit();
  endtask

  task automatic test_single();
    for (int k = 0; k <= S + 1; k++) begin
      drive(k == 0, 3'd3, 8'd12, 8'd10, 0, 1);
      n_tests++;
      if (arrive !== (k == S)) begin
        n_fail++;
        $display("FAIL single_latency: cycle %0d arrive %b want %b",
                 k, arrive, (k == S));
      end
      if (k == S) begin
        n_tests++;
        if ({arrive_id, product, push_out_n} !== {3'd3, 16'd120, 1'b0}) begin
          n_fail++;
          $display("FAIL single_data: got id %0d prod %0d pn %b want 3 120 0",
                   arrive_id, product, push_out_n);
        end
      end
      if (k >= 1) begin
        n_tests++;
        if (census !== ((k <= S) ? 3'd1 : 3'd0)) begin
          n_fail++;
          $display("FAIL single_census: cycle %0d got %0d", k, census);
        end
      end
      commit();
    end
  endtask

  task automatic test_tc();
    bit seen = 0;
    drive(1, 3'd1, 8'hFF, 8'h02, 0, 1); commit();
    for (int k = 0; k < 10 && !seen; k++) begin
      drive(0, 3'd0, 8'd0, 8'd0, 0, 1);
      if (arrive === 1'b1) begin
        seen = 1;
        n_tests++;
        if (product !== 16'h01FE || tc_product !== 16'hFFFE) begin
          n_fail++;
          $display("FAIL tc_product: got %h/%h want 01fe/fffe",
                   product, tc_product);
        end
      end
      commit();
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL tc_timeout: arrive 0 want 1 within 10 cycles");
    end
  endtask

  task automatic test_stall_fill();
    for (int k = 0; k < 6; k++) begin
      drive(1, 3'(k), 8'($urandom), 8'($urandom), 1, 1);
      n_tests++;
      if (pipe_full !== (k >= 4)) begin
        n_fail++;
        $display("FAIL fill_full: launch %0d got %b want %b",
                 k, pipe_full, (k >= 4));
      end
      if (k == 4) begin
        n_tests++;
        if (census !== 3'd4) begin
          n_fail++;
          $display("FAIL fill_census: got %0d want 4", census);
        end
      end
      commit();
    end
    drive(0, 3'd0, 8'd0, 8'd0, 1, 1);
    n_tests++;
    if (pipe_ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL fill_ovf: got %b want 1", pipe_ovf);
    end
    commit();
    for (int j = 0; j < 4; j++) begin
      drive(0, 3'd0, 8'd0, 8'd0, 0, 1);
      n_tests++;
      if ({arrive, arrive_id} !== {1'b1, 3'(j)}) begin
        n_fail++;
        $display("FAIL fill_order: got arrive %b id %0d want 1 %0d",
                 arrive, arrive_id, j);
      end
      commit();
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      drive(1, 3'(k), 8'($urandom), 8'($urandom), 1, 1); commit();
    end
    for (int k = 0; k < 10; k++) begin
      drive(1, 3'(k + 4), 8'($urandom), 8'($urandom), 0, 1);
      n_tests++;
      if ({pipe_full, census, arrive, push_out_n, en_bus}
          !== {1'b0, 3'd4, 1'b1, 1'b0, 4'hF}) begin
        n_fail++;
        $display("FAIL b2b_ctrl: cyc %0d full %b cen %0d arr %b pn %b en %b want 0 4 1 0 1111",
                 k, pipe_full, census, arrive, push_out_n, en_bus);
      end
      n_tests++;
      if ({arrive_id, product} !== {3'(k), e_pu}) begin
        n_fail++;
        $display("FAIL b2b_data: cyc %0d got id %0d prod %h want %0d %h",
                 k, arrive_id, product, 3'(k), e_pu);
      end
      commit();
    end
    for (int k = 0; k < 4; k++) begin
      drive(0, 3'd0, 8'd0, 8'd0, 0, 1); commit();
    end
  endtask

  task automatic test_init();
    for (int k = 0; k < 3; k++) begin
      drive(1, 3'(k + 1), 8'($urandom), 8'($urandom), 1, 1); commit();
    end
    drive(0, 3'd0, 8'd0, 8'd0, 1, 0); commit();
    drive(0, 3'd0, 8'd0, 8'd0, 0, 1);
    n_tests++;
    if ({arrive, census, pipe_ovf} !== 5'd0) begin
      n_fail++;
      $display("FAIL init_clear: got arr %b cen %0d ovf %b want 0 0 0",
               arrive, census, pipe_ovf);
    end
    commit();
    for (int k = 0; k < 6; k++) begin
      drive(0, 3'd0, 8'd0, 8'd0, 0, 1);
      n_tests++;
      if (arrive !== 1'b0) begin
        n_fail++;
        $display("FAIL init_stale: cyc %0d arrive %b want 0", k, arrive);
      end
      commit();
    end
    for (int k = 0; k <= S; k++) begin
      drive(k == 0, 3'd6, 8'd33, 8'd5, 0, 1);
      n_tests++;
      if (arrive !== (k == S)) begin
        n_fail++;
        $display("FAIL init_relaunch: cyc %0d arrive %b want %b",
                 k, arrive, (k == S));
      end
      if (k == S) begin
        n_tests++;
        if ({arrive_id, product} !== {3'd6, 16'd165}) begin
          n_fail++;
          $display("FAIL init_relaunch_data: got %0d %0d want 6 165",
                   arrive_id, product);
        end
      end
      commit();
    end
  endtask

  task automatic test_random();
    bit l, acn, ini;
    for (int k = 0; k < 600; k++) begin
      l   = ($urandom_range(0, 3) != 0);
      acn = ($urandom_range(0, 2) == 0);
      ini = ($urandom_range(0, 63) != 0);
      drive(l, 3'($urandom), 8'($urandom), 8'($urandom), acn, ini);
      n_tests++;
      if ({arrive, push_out_n, pipe_full, pipe_ovf, census, en_bus}
          !== {e_arrive, e_push_n, e_full, e_ovf, 3'(e_census), e_en}) begin
        n_fail++;
        $display("FAIL rand_ctrl: cyc %0d got %b want %b", k,
                 {arrive, push_out_n, pipe_full, pipe_ovf, census, en_bus},
                 {e_arrive, e_push_n, e_full, e_ovf, 3'(e_census), e_en});
      end
      n_tests++;
      if ({tc_arrive, tc_push_n, tc_full, tc_ovf, tc_census, tc_en}
          !== {e_arrive, e_push_n, e_full, e_ovf, 3'(e_census), e_en}) begin
        n_fail++;
        $display("FAIL rand_tc_ctrl: cyc %0d got %b want %b", k,
                 {tc_arrive, tc_push_n, tc_full, tc_ovf, tc_census, tc_en},
                 {e_arrive, e_push_n, e_full, e_ovf, 3'(e_census), e_en});
      end
      if (e_arrive) begin
        n_tests++;
        if ({arrive_id, product, tc_id, tc_product}
            !== {e_id, e_pu, e_id, e_ps}) begin
          n_fail++;
          $display("FAIL rand_data: cyc %0d got %0d %h %0d %h want %0d %h %0d %h",
                   k, arrive_id, product, tc_id, tc_product,
                   e_id, e_pu, e_id, e_ps);
        end
      end
      commit();
    end
  endtask

`ifdef LP_PIPE_MULT_MGR_STALL_CNT_EN
  task automatic test_stall_cnt();
    drive(0, 3'd0, 8'd0, 8'd0, 1, 0); commit();
    drive(1, 3'd2, 8'd3, 8'd3, 1, 1); commit();
    for (int k = 1; k < S; k++) begin
      drive(0, 3'd0, 8'd0, 8'd0, 1, 1); commit();
    end
    for (int j = 0; j < 70000; j++) begin
      drive(0, 3'd0, 8'd0, 8'd0, 1, 1);
      if (j == 0 || j == 100) begin
        n_tests++;
        if ({arrive, stall_cnt} !== {1'b1, 16'(j)}) begin
          n_fail++;
          $display("FAIL stall_cnt_run: j %0d arr %b cnt %0d want 1 %0d",
                   j, arrive, stall_cnt, j);
        end
      end
      commit();
    end
    drive(0, 3'd0, 8'd0, 8'd0, 1, 1);
    n_tests++;
    if (stall_cnt !== 16'hFFFF || tc_stall_cnt !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL stall_cnt_sat: got %h/%h want ffff",
               stall_cnt, tc_stall_cnt);
    end
    commit();
    drive(0, 3'd0, 8'd0, 8'd0, 0, 0); commit();
    drive(0, 3'd0, 8'd0, 8'd0, 0, 1);
    n_tests++;
    if (stall_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL stall_cnt_clear: got %h want 0", stall_cnt);
    end
    commit();
  endtask
`endif

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_tc();
    test_stall_fill();
    test_back_to_back();
    test_init();
    test_random();
`ifdef LP_PIPE_MULT_MGR_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
